// File: rtl/axilite_slave_regfile.sv
// rtl/axilite_slave_regfile.sv - AXI4-Lite responder exposing a bank of 32-bit control registers
module axilite_slave_regfile #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int REG_NUM        = 16,
   parameter int REG_ADDR_LSB   = 2
) (
   input  logic                          axi_clk,
   input  logic                          reset,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                    s_axi_awprot,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                    s_axi_arprot,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   output logic [REG_NUM*AXI_DATA_WIDTH-1:0] reg_out,
   output logic [REG_NUM-1:0]            reg_wr_pulse,
   input  logic [AXI_DATA_WIDTH-1:0]     status_in
);

   localparam int IDX_W  = $clog2(REG_NUM);
   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam logic [IDX_W-1:0] RO_IDX = IDX_W'(REG_NUM - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   logic [AXI_DATA_WIDTH-1:0] regs [REG_NUM];

   w_state_t                  w_state_q, w_state_n;
   logic                      aw_held_q, aw_held_n;
   logic                      w_held_q, w_held_n;
   logic [IDX_W-1:0]          aw_idx_q, aw_idx_n;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_n;
   logic [STRB_W-1:0]         wstrb_q, wstrb_n;
   logic                      awready_q, awready_n;
   logic                      wready_q, wready_n;
   logic                      bvalid_q, bvalid_n;
   logic [1:0]                bresp_q, bresp_n;
   logic [REG_NUM-1:0]        pulse_q, pulse_n;
   logic                      commit;

   r_state_t                  r_state_q, r_state_n;
   logic                      arready_q, arready_n;
   logic                      rvalid_q, rvalid_n;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_n;
   logic [1:0]                rresp_q, rresp_n;

   logic                      aw_fire, w_fire;
   logic [IDX_W-1:0]          aw_idx_in, ar_idx_in;

   // Protection bits and upper address bits carry no meaning for this bank.
   logic unused_bits;
   assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

   assign aw_fire   = s_axi_awvalid && awready_q;
   assign w_fire    = s_axi_wvalid && wready_q;
   assign aw_idx_in = s_axi_awaddr[REG_ADDR_LSB +: IDX_W];
   assign ar_idx_in = s_axi_araddr[REG_ADDR_LSB +: IDX_W];

   // Write FSM next state: AW and W are captured independently, then committed together.
   always_comb begin
      w_state_n = w_state_q;
      aw_held_n = aw_held_q;
      w_held_n  = w_held_q;
      aw_idx_n  = aw_idx_q;
      wdata_n   = wdata_q;
      wstrb_n   = wstrb_q;
      awready_n = awready_q;
      wready_n  = wready_q;
      bvalid_n  = bvalid_q;
      bresp_n   = bresp_q;
      pulse_n   = '0;
      commit    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_fire) begin
               aw_held_n = 1'b1;
               aw_idx_n  = aw_idx_in;
            end
            if (w_fire) begin
               w_held_n = 1'b1;
               wdata_n  = s_axi_wdata;
               wstrb_n  = s_axi_wstrb;
            end
            if (aw_held_n && w_held_n) begin
               w_state_n = W_ADDR_DATA;
               awready_n = 1'b0;
               wready_n  = 1'b0;
               // Pulse is launched on entry so it is high during the commit cycle.
               if (aw_idx_n != RO_IDX) pulse_n[aw_idx_n] = 1'b1;
            end else begin
               awready_n = !aw_held_n;
               wready_n  = !w_held_n;
            end
         end
         W_ADDR_DATA: begin
            commit    = 1'b1;
            aw_held_n = 1'b0;
            w_held_n  = 1'b0;
            bvalid_n  = 1'b1;
            bresp_n   = (aw_idx_q == RO_IDX) ? RESP_SLVERR : RESP_OKAY;
            w_state_n = W_RESP;
         end
         W_RESP: begin
            if (bvalid_q && s_axi_bready) begin
               bvalid_n  = 1'b0;
               awready_n = 1'b1;
               wready_n  = 1'b1;
               w_state_n = W_IDLE;
            end
         end
         default: w_state_n = W_IDLE;
      endcase
   end

   // Write FSM state and registered write-channel outputs.
   always_ff @(posedge axi_clk or posedge reset) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         pulse_q   <= '0;
      end else begin
         w_state_q <= w_state_n;
         aw_held_q <= aw_held_n;
         w_held_q  <= w_held_n;
         aw_idx_q  <= aw_idx_n;
         wdata_q   <= wdata_n;
         wstrb_q   <= wstrb_n;
         awready_q <= awready_n;
         wready_q  <= wready_n;
         bvalid_q  <= bvalid_n;
         bresp_q   <= bresp_n;
         pulse_q   <= pulse_n;
      end
   end

   // Register bank: byte-masked commit; the status index is never stored.
   always_ff @(posedge axi_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else if (commit && aw_idx_q != RO_IDX) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) regs[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   // Read FSM next state: data is sampled at AR acceptance and held until taken.
   always_comb begin
      r_state_n = r_state_q;
      arready_n = arready_q;
      rvalid_n  = rvalid_q;
      rdata_n   = rdata_q;
      rresp_n   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (s_axi_arvalid && arready_q) begin
               r_state_n = R_DATA;
               arready_n = 1'b0;
               rvalid_n  = 1'b1;
               rdata_n   = (ar_idx_in == RO_IDX) ? status_in : regs[ar_idx_in];
               rresp_n   = RESP_OKAY;
            end else begin
               arready_n = 1'b1;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               r_state_n = R_IDLE;
               rvalid_n  = 1'b0;
               arready_n = 1'b1;
            end
         end
         default: r_state_n = R_IDLE;
      endcase
   end

   // Read FSM state and registered read-channel outputs.
   always_ff @(posedge axi_clk or posedge reset) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_n;
         arready_q <= arready_n;
         rvalid_q  <= rvalid_n;
         rdata_q   <= rdata_n;
         rresp_q   <= rresp_n;
      end
   end

   genvar g;
   generate
      for (g = 0; g < REG_NUM; g++) begin : g_reg_out
         assign reg_out[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[g];
      end
   endgenerate

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_axilite_slave_regfile.sv
// tb/tb_axilite_slave_regfile.sv - randomized self-checking bench for axilite_slave_regfile
module tb_axilite_slave_regfile;

   localparam int NREG = 16;

   logic          axi_clk = 1'b0;
   logic          reset   = 1'b1;
   logic [31:0]   awaddr  = '0;
   logic [2:0]    awprot  = '0;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [31:0]   wdata   = '0;
   logic [3:0]    wstrb   = '0;
   logic          wvalid  = 1'b0;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready  = 1'b0;
   logic [31:0]   araddr  = '0;
   logic [2:0]    arprot  = '0;
   logic          arvalid = 1'b0;
   logic          arready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready  = 1'b0;
   logic [NREG*32-1:0] reg_out;
   logic [NREG-1:0]    reg_wr_pulse;
   logic [31:0]   status_in = '0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] model [NREG];

   axilite_slave_regfile dut (
      .axi_clk(axi_clk), .reset(reset),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in)
   );

   always #5 axi_clk = ~axi_clk;

   task automatic check_val(input string tag, input logic [NREG*32-1:0] got, input logic [NREG*32-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [NREG*32-1:0] model_flat();
      logic [NREG*32-1:0] f;
      for (int i = 0; i < NREG; i++) f[i*32 +: 32] = model[i];
      return f;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NREG; i++) model[i] = '0;
   endtask

   // Drives one write with per-channel start delays and bready backpressure,
   // checking handshake timing, response, pulse and resulting register contents.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
      int idx, cyc;
      bit aw_done, w_done;
      logic [1:0] exp_resp;
      logic [NREG-1:0] exp_pulse;
      idx       = int'(addr[5:2]);
      exp_resp  = (idx == NREG-1) ? 2'b10 : 2'b00;
      exp_pulse = (idx == NREG-1) ? '0 : (NREG'(1) << idx);
      cyc = 0; aw_done = 0; w_done = 0;
      while (!(aw_done && w_done)) begin
         @(negedge axi_clk);
         if (aw_done) check_val("awready_low_after_aw", awready, 0);
         if (w_done)  check_val("wready_low_after_w", wready, 0);
         awaddr  = addr;
         wdata   = data;
         wstrb   = strb;
         awvalid = !aw_done && cyc >= aw_dly;
         wvalid  = !w_done && cyc >= w_dly;
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready)   w_done  = 1;
         cyc++;
         if (cyc > 100) begin
            check_val("write_accept_timeout", 0, 1);
            awvalid = 0; wvalid = 0;
            return;
         end
      end
      @(negedge axi_clk);
      awvalid = 0; wvalid = 0;
      check_val("bvalid_not_early", bvalid, 0);
      check_val("wr_pulse_commit", reg_wr_pulse, exp_pulse);
      if (idx != NREG-1)
         for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      @(negedge axi_clk);
      check_val("bvalid_latency", bvalid, 1);
      check_val("bresp", bresp, exp_resp);
      check_val("wr_pulse_cleared", reg_wr_pulse, 0);
      check_val("reg_out_after_write", reg_out, model_flat());
      for (int k = 0; k < b_dly; k++) begin
         @(negedge axi_clk);
         check_val("bvalid_held", bvalid, 1);
         check_val("bresp_stable", bresp, exp_resp);
         check_val("awready_blocked", awready, 0);
         check_val("wready_blocked", wready, 0);
      end
      bready = 1;
      @(negedge axi_clk);
      bready = 0;
      check_val("bvalid_dropped", bvalid, 0);
      check_val("awready_reopen", awready, 1);
      check_val("wready_reopen", wready, 1);
   endtask

   // Drives one read, changes status_in right after acceptance and holds rready low for r_dly cycles.
   task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
      int idx, guard;
      logic [31:0] exp;
      idx = int'(addr[5:2]);
      for (int k = 0; k < ar_dly; k++) @(negedge axi_clk);
      @(negedge axi_clk);
      araddr  = addr;
      arvalid = 1;
      guard   = 0;
      while (!arready) begin
         @(negedge axi_clk);
         guard++;
         if (guard > 50) begin
            check_val("read_accept_timeout", 0, 1);
            arvalid = 0;
            return;
         end
      end
      exp = (idx == NREG-1) ? status_in : model[idx];
      @(negedge axi_clk);
      arvalid   = 0;
      status_in = $urandom;
      check_val("rvalid_latency", rvalid, 1);
      check_val("rdata", rdata, exp);
      check_val("rresp", rresp, 0);
      check_val("arready_busy", arready, 0);
      for (int k = 0; k < r_dly; k++) begin
         @(negedge axi_clk);
         check_val("rvalid_held", rvalid, 1);
         check_val("rdata_stable", rdata, exp);
      end
      rready = 1;
      @(negedge axi_clk);
      rready = 0;
      check_val("rvalid_dropped", rvalid, 0);
      check_val("arready_reopen", arready, 1);
   endtask

   initial begin
      model_clear();
      status_in = 32'h0;
      repeat (3) @(negedge axi_clk);
      check_val("rst_awready", awready, 0);
      check_val("rst_wready", wready, 0);
      check_val("rst_arready", arready, 0);
      check_val("rst_bvalid", bvalid, 0);
      check_val("rst_rvalid", rvalid, 0);
      check_val("rst_bresp", bresp, 0);
      check_val("rst_rdata", rdata, 0);
      check_val("rst_reg_out", reg_out, 0);
      check_val("rst_pulse", reg_wr_pulse, 0);
      reset = 0;
      @(negedge axi_clk);
      check_val("ready_after_release_aw", awready, 1);
      check_val("ready_after_release_w", wready, 1);
      check_val("ready_after_release_ar", arready, 1);

      // Same-cycle AW/W write.
      axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      check_val("reg1_deadbeef", reg_out[63:32], 32'hDEADBEEF);

      // W ahead of AW, partial strobe over a preloaded register.
      axi_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      axi_write(32'h8, 32'h12345678, 4'h3, 3, 0, 0);
      check_val("reg2_merge", reg_out[95:64], 32'hFFFF5678);

      // Response backpressure.
      axi_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 5);

      // Read-back with rready held low.
      axi_read(32'h4, 0, 3);

      // Read-only status index.
      status_in = 32'hA5A5A5A5;
      axi_read(32'h3C, 0, 0);
      axi_write(32'h3C, 32'h11223344, 4'hF, 0, 0, 0);
      check_val("status_reg_unchanged", reg_out[511:480], 0);

      // Upper address bits alias onto the register index.
      axi_write(32'h44, 32'h1, 4'hF, 0, 0, 0);
      check_val("alias_reg1", reg_out[63:32], 32'h1);

      // Randomized traffic across the whole address space.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 1) == 0)
            axi_write($urandom, $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            axi_read($urandom, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // Reset while a read response is pending.
      @(negedge axi_clk);
      araddr  = 32'h4;
      arvalid = 1;
      @(negedge axi_clk);
      arvalid = 0;
      check_val("pre_reset_rvalid", rvalid, 1);
      reset = 1;
      #1;
      check_val("reset_drops_rvalid", rvalid, 0);
      check_val("reset_clears_regs", reg_out, 0);
      check_val("reset_arready", arready, 0);
      model_clear();
      @(negedge axi_clk);
      reset = 0;
      @(negedge axi_clk);
      axi_write(32'h0, 32'h0BADC0DE, 4'hF, 1, 0, 0);
      axi_read(32'h0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axilite_slave_regfile.md
Name: axilite_slave_regfile

Overview: AXI4-Lite slave (responder) exposing a bank of 32-bit read/write control registers to a design-side user port. It is the far end of the AXI4-Lite master path: it accepts AW/W/B and AR/R transactions on the AXI clock and drives register contents out to the game logic. The game logic can also load read-only status values. Single clock domain; no CDC.

Parameters:
AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
AXI_ADDR_WIDTH, 32, address bus width.
REG_NUM, 16, number of registers; must be a power of two, 2..64.
REG_ADDR_LSB, 2, byte-offset bits ignored in the register index (log2(AXI_DATA_WIDTH/8)).

Ports:
axi_clk  input  1  single clock for all logic.
reset  input  1  asynchronous, active-high reset.
s_axi_awaddr  input  AXI_ADDR_WIDTH  write address.
s_axi_awprot  input  3  ignored.
s_axi_awvalid  input  1  write address valid.
s_axi_awready  output  1  write address ready.
s_axi_wdata  input  AXI_DATA_WIDTH  write data.
s_axi_wstrb  input  AXI_DATA_WIDTH/8  byte strobes.
s_axi_wvalid  input  1  write data valid.
s_axi_wready  output  1  write data ready.
s_axi_bresp  output  2  write response.
s_axi_bvalid  output  1  write response valid.
s_axi_bready  input  1  write response ready.
s_axi_araddr  input  AXI_ADDR_WIDTH  read address.
s_axi_arprot  input  3  ignored.
s_axi_arvalid  input  1  read address valid.
s_axi_arready  output  1  read address ready.
s_axi_rdata  output  AXI_DATA_WIDTH  read data.
s_axi_rresp  output  2  read response.
s_axi_rvalid  output  1  read data valid.
s_axi_rready  input  1  read data ready.
reg_out  output  REG_NUM*AXI_DATA_WIDTH  flattened register contents; register i is at bits [32i+31:32i].
reg_wr_pulse  output  REG_NUM  one-cycle strobe for register i after an AXI write commits to it.
status_in  input  AXI_DATA_WIDTH  status word read at the last index (REG_NUM-1). That index is read-only.

Behaviour:
- Reset values: all registers 0, reg_wr_pulse 0. The ready outputs awready, wready and arready reset to 0 and assert 1 cycle after reset deasserts. bvalid and rvalid reset to 0. bresp, rresp and rdata reset to 0.
- Write FSM states: W_IDLE, W_ADDR_DATA, W_RESP.
- W_IDLE: awready=1 and wready=1. AW and W are each captured independently in holding registers when valid&&ready. Each channel's ready drops once that channel is captured. AW and W may arrive in the same cycle or in either order.
- When both AW and W are held, go to W_ADDR_DATA.
- W_ADDR_DATA (1 cycle): commit the write.
  - Index = awaddr[REG_ADDR_LSB +: log2(REG_NUM)]; upper address bits are ignored.
  - Apply byte-wise per wstrb; strb 0 leaves the register unchanged.
  - Pulse reg_wr_pulse[index] for this 1 cycle. The new value is visible on reg_out the next cycle.
  - A write to index REG_NUM-1 is discarded, no pulse is issued, and bresp=SLVERR(2'b10). Otherwise bresp=OKAY(2'b00).
  - Go to W_RESP.
- W_RESP: bvalid=1 and is held until bready. Return to W_IDLE on the cycle after the handshake.
  - Minimum write latency: AW&W accepted in cycle N, commit in N+1, bvalid in N+2.
- Read FSM states: R_IDLE, R_DATA.
- R_IDLE: arready=1. On arvalid&&arready, latch the index and go to R_DATA with rvalid=1 in the next cycle.
  - rdata = register[index], or status_in sampled at AR acceptance for index REG_NUM-1.
  - rresp=OKAY.
- R_DATA: rdata and rresp are held stable while rvalid&&!rready. On handshake, return to R_IDLE, where arready=1 the following cycle.
  - Maximum throughput: one read per 2 cycles.
- Read and write FSMs are independent. A read and a write to the same index with AR accepted in the same cycle as the write commit return the old value.
- Upper-address aliasing: index wraps modulo REG_NUM.
- Reset mid-transaction: all FSMs return to IDLE immediately and pending B/R responses are dropped. Registers clear.
- Outputs never depend combinationally on inputs; all are registered.

Test Plan:
- Reset then single write: AW addr 0x4 and W 0xDEADBEEF with strb 0xF in the same cycle -> bvalid 2 cycles later with bresp=00; reg_out[63:32]=0xDEADBEEF; reg_wr_pulse[1] high for 1 cycle.
- W before AW: W 0x12345678 strb 0x3 on cycle 0, AW addr 0x8 on cycle 3, register 2 preloaded with 0xFFFFFFFF -> register 2 = 0xFFFF5678; wready low from cycle 1 until bresp accepted.
- Backpressure: bready held low for 5 cycles -> bvalid stays 1 and bresp stable; no new AW accepted (awready=0) until the handshake.
- Read-back: read addr 0x4 after the first test with rready low for 3 cycles -> rvalid 1 cycle after AR, rdata=0xDEADBEEF held stable, rresp=00.
- Status/read-only: status_in=0xA5A5A5A5, read addr 0x3C -> rdata 0xA5A5A5A5; write 0x3C -> bresp=10, no reg_wr_pulse[15], value unchanged.
- Aliasing and reset: write addr 0x44 with 0x1 -> register 1=0x1; assert reset during R_DATA -> rvalid drops immediately and reg_out=0.
